gelismis_dallanma_ongorucu: RTL and testbench

GELISMIS_DALLANMA_ONGORUCU -- requirements
Module: gelismis_dallanma_ongorucu

---
 rtl/gelismis_dallanma_ongorucu.sv | 121 ++++++++++++
 tb/tb_gelismis_dallanma_ongorucu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gelismis_dallanma_ongorucu.sv
// gelismis_dallanma_ongorucu: gshare branch predictor with a BTB, a return-address stack and performance counters.
//   clk_i                  : clock, all state changes on the rising edge
//   rst_i                  : synchronous active-low reset
//   ps_i / ps_gecerli_i    : fetch PC to predict and its valid flag
//   atladi_o / ongoru_o    : predicted taken flag and predicted target (combinational)
//   yurut_*                : resolve-side update port (PC, strobe, outcome, target, mispredict, call, return)
//   dogru_sayac_o          : saturating count of correct predictions
//   yanlis_sayac_o         : saturating count of mispredictions
module gelismis_dallanma_ongorucu #(
    parameter int BTB_SATIR    = 32,
    parameter int BHT_SATIR    = 64,
    parameter int RAS_DERINLIK = 4,
    parameter int SAYAC_BIT    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          ps_i,
    input  logic                 ps_gecerli_i,
    output logic                 atladi_o,
    output logic [31:0]          ongoru_o,
    input  logic [31:0]          yurut_ps_i,
    input  logic                 yurut_guncelle_i,
    input  logic                 yurut_atladi_i,
    input  logic [31:0]          yurut_atlanan_adres_i,
    input  logic                 yurut_hatali_tahmin_i,
    input  logic                 yurut_cagri_i,
    input  logic                 yurut_donus_i,
    output logic [SAYAC_BIT-1:0] dogru_sayac_o,
    output logic [SAYAC_BIT-1:0] yanlis_sayac_o
);
    localparam int BI = $clog2(BTB_SATIR);
    localparam int GB = $clog2(BHT_SATIR);
    localparam int RI = $clog2(RAS_DERINLIK);
    localparam int TW = 30 - BI;
    localparam logic [RI-1:0]        P_BIR     = 1;
    localparam logic [RI:0]          S_BIR     = 1;
    localparam logic [RI:0]          RAS_DOLU  = (RI+1)'(RAS_DERINLIK);
    localparam logic [SAYAC_BIT-1:0] C_BIR     = 1;
    localparam logic [SAYAC_BIT-1:0] SAYAC_MAX = '1;

    logic [BTB_SATIR-1:0] btb_gecerli, btb_donus;
    logic [TW-1:0]        btb_etiket [BTB_SATIR];
    logic [31:0]          btb_hedef  [BTB_SATIR];
    logic [1:0]           bht        [BHT_SATIR];
    logic [GB-1:0]        ggy;
    logic [31:0]          ras        [RAS_DERINLIK];
    logic [RI-1:0]        ras_ptr;
    logic [RI:0]          ras_say;
    logic [SAYAC_BIT-1:0] dogru, yanlis;

    logic [BI-1:0] l_idx, u_idx;
    logic [GB-1:0] l_bht, u_bht;
    logic          l_hit, l_ras, push, pop, degis;
    logic [31:0]   ras_ust, donus_adr;
    logic          unused_ps;

    assign unused_ps = ^ps_i[1:0];
    assign l_idx     = ps_i[2 +: BI];
    assign l_bht     = ps_i[2 +: GB] ^ ggy;
    // ras_ptr points at the next free slot, so the top is one below it
    assign ras_ust   = ras[ras_ptr - P_BIR];
    assign l_hit     = rst_i & ps_gecerli_i & btb_gecerli[l_idx] & (btb_etiket[l_idx] == ps_i[31:2+BI]);
    assign l_ras     = l_hit & btb_donus[l_idx] & (ras_say != '0);
    assign atladi_o  = l_ras | (l_hit & bht[l_bht][1]);
    assign ongoru_o  = l_ras ? ras_ust : (l_hit ? btb_hedef[l_idx] : '0);

    assign u_idx     = yurut_ps_i[2 +: BI];
    assign u_bht     = yurut_ps_i[2 +: GB] ^ ggy;
    assign donus_adr = yurut_ps_i + 32'd4;
    // call+return on an empty stack degenerates to a plain push
    assign push      = yurut_cagri_i & (~yurut_donus_i | (ras_say == '0));
    assign pop       = yurut_donus_i & ~yurut_cagri_i & (ras_say != '0);
    assign degis     = yurut_cagri_i & yurut_donus_i & (ras_say != '0);

    assign dogru_sayac_o  = dogru;
    assign yanlis_sayac_o = yanlis;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            btb_gecerli <= '0;
            btb_donus   <= '0;
            for (int i = 0; i < BTB_SATIR; i++) begin
                btb_etiket[i] <= '0;
                btb_hedef[i]  <= '0;
            end
            for (int i = 0; i < BHT_SATIR; i++) bht[i] <= 2'd1;
            for (int i = 0; i < RAS_DERINLIK; i++) ras[i] <= '0;
            ggy     <= '0;
            ras_ptr <= '0;
            ras_say <= '0;
            dogru   <= '0;
            yanlis  <= '0;
        end else if (yurut_guncelle_i) begin
            bht[u_bht] <= yurut_atladi_i ? ((bht[u_bht] == 2'd3) ? 2'd3 : bht[u_bht] + 2'd1)
                                         : ((bht[u_bht] == 2'd0) ? 2'd0 : bht[u_bht] - 2'd1);
            ggy <= {ggy[GB-2:0], yurut_atladi_i};
            if (yurut_atladi_i) begin
                btb_gecerli[u_idx] <= 1'b1;
                btb_donus[u_idx]   <= yurut_donus_i;
                btb_etiket[u_idx]  <= yurut_ps_i[31:2+BI];
                btb_hedef[u_idx]   <= yurut_atlanan_adres_i;
            end
            // when full the write slot is the oldest entry, so overflow overwrites it
            if (push) begin
                ras[ras_ptr] <= donus_adr;
                ras_ptr      <= ras_ptr + P_BIR;
                if (ras_say != RAS_DOLU) ras_say <= ras_say + S_BIR;
            end
            if (pop) begin
                ras_ptr <= ras_ptr - P_BIR;
                ras_say <= ras_say - S_BIR;
            end
            if (degis) ras[ras_ptr - P_BIR] <= donus_adr;
            if (yurut_hatali_tahmin_i) begin
                if (yanlis != SAYAC_MAX) yanlis <= yanlis + C_BIR;
            end else if (dogru != SAYAC_MAX) begin
                dogru <= dogru + C_BIR;
            end
        end
    end
endmodule

// File: tb/tb_gelismis_dallanma_ongorucu.sv
// tb_gelismis_dallanma_ongorucu: directed self-checking bench for the branch predictor.
module tb_gelismis_dallanma_ongorucu;
    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] ps_i;
    logic        ps_gecerli_i;
    logic        atladi_o;
    logic [31:0] ongoru_o;
    logic [31:0] yurut_ps_i;
    logic        yurut_guncelle_i;
    logic        yurut_atladi_i;
    logic [31:0] yurut_atlanan_adres_i;
    logic        yurut_hatali_tahmin_i;
    logic        yurut_cagri_i;
    logic        yurut_donus_i;
    logic [3:0]  dogru_sayac_o;
    logic [3:0]  yanlis_sayac_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gelismis_dallanma_ongorucu #(.SAYAC_BIT(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .ps_i(ps_i), .ps_gecerli_i(ps_gecerli_i),
        .atladi_o(atladi_o), .ongoru_o(ongoru_o), .yurut_ps_i(yurut_ps_i),
        .yurut_guncelle_i(yurut_guncelle_i), .yurut_atladi_i(yurut_atladi_i),
        .yurut_atlanan_adres_i(yurut_atlanan_adres_i),
        .yurut_hatali_tahmin_i(yurut_hatali_tahmin_i), .yurut_cagri_i(yurut_cagri_i),
        .yurut_donus_i(yurut_donus_i), .dogru_sayac_o(dogru_sayac_o),
        .yanlis_sayac_o(yanlis_sayac_o)
    );

    typedef struct {
        logic [31:0] ps;
        logic        atl;
        logic [31:0] hedef;
        logic        cagri;
        logic        donus;
        logic [31:0] exp_ong;
        logic        chk_atl;
    } ras_vec_t;

    ras_vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic look(input string nm, input logic [31:0] p, input logic ea, input logic [31:0] eo);
        ps_i = p;
        ps_gecerli_i = 1'b1;
        #1;
        chk({nm, "_atl"}, {31'd0, atladi_o}, {31'd0, ea});
        chk({nm, "_ong"}, ongoru_o, eo);
    endtask

    task automatic upd(input logic [31:0] p, input logic a, input logic [31:0] h,
                       input logic hat, input logic c, input logic d);
        yurut_ps_i = p;
        yurut_atladi_i = a;
        yurut_atlanan_adres_i = h;
        yurut_hatali_tahmin_i = hat;
        yurut_cagri_i = c;
        yurut_donus_i = d;
        yurut_guncelle_i = 1'b1;
        @(posedge clk);
        #1;
        yurut_guncelle_i = 1'b0;
        yurut_atladi_i = 1'b0;
        yurut_hatali_tahmin_i = 1'b0;
        yurut_cagri_i = 1'b0;
        yurut_donus_i = 1'b0;
    endtask

    // six not-taken updates shift the history back to zero; 0x8FC indexes counters far from index 0
    task automatic flush();
        repeat (6) upd(32'h8FC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{32'h10,   1'b0, 32'h0,    1'b1, 1'b0, 32'h14,   1'b1};
        vecs[1]  = '{32'h20,   1'b0, 32'h0,    1'b1, 1'b0, 32'h24,   1'b1};
        vecs[2]  = '{32'h30,   1'b0, 32'h0,    1'b1, 1'b0, 32'h34,   1'b1};
        vecs[3]  = '{32'h40,   1'b0, 32'h0,    1'b1, 1'b0, 32'h44,   1'b1};
        vecs[4]  = '{32'h50,   1'b0, 32'h0,    1'b1, 1'b0, 32'h54,   1'b1};
        vecs[5]  = '{32'h3000, 1'b1, 32'h7000, 1'b0, 1'b1, 32'h44,   1'b1};
        vecs[6]  = '{32'h3000, 1'b1, 32'h7000, 1'b0, 1'b1, 32'h34,   1'b1};
        vecs[7]  = '{32'h3000, 1'b1, 32'h7000, 1'b0, 1'b1, 32'h24,   1'b1};
        vecs[8]  = '{32'h3000, 1'b1, 32'h7000, 1'b0, 1'b1, 32'h7000, 1'b0};
        vecs[9]  = '{32'h3000, 1'b1, 32'h7000, 1'b0, 1'b1, 32'h7000, 1'b0};
        vecs[10] = '{32'h60,   1'b0, 32'h0,    1'b1, 1'b1, 32'h64,   1'b1};
        vecs[11] = '{32'h70,   1'b0, 32'h0,    1'b1, 1'b1, 32'h74,   1'b1};
        vecs[12] = '{32'h3000, 1'b1, 32'h7000, 1'b0, 1'b1, 32'h7000, 1'b0};

        ps_i = '0;
        ps_gecerli_i = 1'b0;
        yurut_ps_i = 32'h100;
        yurut_atladi_i = 1'b1;
        yurut_atlanan_adres_i = 32'h200;
        yurut_hatali_tahmin_i = 1'b0;
        yurut_cagri_i = 1'b0;
        yurut_donus_i = 1'b0;
        yurut_guncelle_i = 1'b1;
        rst_i = 1'b0;

        // updates held during reset must be ignored
        repeat (2) @(posedge clk);
        #1;
        look("in_reset", 32'h100, 1'b0, 32'h0);
        chk("in_reset_dogru", {28'd0, dogru_sayac_o}, 32'd0);
        yurut_guncelle_i = 1'b0;
        yurut_atladi_i = 1'b0;
        rst_i = 1'b1;
        look("cold", 32'h100, 1'b0, 32'h0);
        chk("cold_dogru", {28'd0, dogru_sayac_o}, 32'd0);
        chk("cold_yanlis", {28'd0, yanlis_sayac_o}, 32'd0);

        // training: the lookup in the update cycle still sees the empty BTB
        yurut_ps_i = 32'h100;
        yurut_atladi_i = 1'b1;
        yurut_atlanan_adres_i = 32'h200;
        yurut_guncelle_i = 1'b1;
        look("same_cycle", 32'h100, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        yurut_guncelle_i = 1'b0;
        yurut_atladi_i = 1'b0;
        look("train1", 32'h100, 1'b0, 32'h200);
        upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        flush();
        look("train_ggy0", 32'h100, 1'b1, 32'h200);
        ps_gecerli_i = 1'b0;
        #1;
        chk("invalid_atl", {31'd0, atladi_o}, 32'd0);
        chk("invalid_ong", ongoru_o, 32'd0);
        look("tag_miss", 32'h1100, 1'b0, 32'h0);

        // saturation at 3: five taken keep predicting taken, then 3->2->1
        for (int i = 0; i < 5; i++) begin
            upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
            flush();
            look($sformatf("sat_taken%0d", i), 32'h100, 1'b1, 32'h200);
        end
        upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("sat_c2", 32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("sat_c1", 32'h100, 1'b0, 32'h200);
        // saturation at 0: two extra not-taken, then two taken are needed to predict taken again
        repeat (2) upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("sat_c0", 32'h100, 1'b0, 32'h200);
        upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        flush();
        look("sat_up1", 32'h100, 1'b0, 32'h200);
        upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        flush();
        look("sat_up2", 32'h100, 1'b1, 32'h200);

        // RAS: return trained first (pop on empty), then two calls
        do_reset();
        upd(32'h3000, 1'b1, 32'h7000, 1'b0, 1'b0, 1'b1);
        look("ret_empty", 32'h3000, 1'b0, 32'h7000);
        upd(32'h1000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        upd(32'h2000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        look("ras_top2", 32'h3000, 1'b1, 32'h2004);
        upd(32'h3000, 1'b1, 32'h7000, 1'b0, 1'b0, 1'b1);
        look("ras_top1", 32'h3000, 1'b1, 32'h1004);
        upd(32'h3000, 1'b1, 32'h7000, 1'b0, 1'b0, 1'b1);
        look("ras_empty", 32'h3000, 1'b0, 32'h7000);
        upd(32'h3000, 1'b1, 32'h7000, 1'b0, 1'b0, 1'b1);
        look("ras_empty_pop", 32'h3000, 1'b0, 32'h7000);

        // overflow, pops to empty, simultaneous call+return
        for (int i = 0; i < 13; i++) begin
            upd(vecs[i].ps, vecs[i].atl, vecs[i].hedef, 1'b0, vecs[i].cagri, vecs[i].donus);
            ps_i = 32'h3000;
            ps_gecerli_i = 1'b1;
            #1;
            chk($sformatf("ras_vec%0d_ong", i), ongoru_o, vecs[i].exp_ong);
            if (vecs[i].chk_atl) chk($sformatf("ras_vec%0d_atl", i), {31'd0, atladi_o}, 32'd1);
        end

        // performance counters with 4-bit width
        do_reset();
        chk("perf_rst_dogru", {28'd0, dogru_sayac_o}, 32'd0);
        chk("perf_rst_yanlis", {28'd0, yanlis_sayac_o}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            upd(32'h8FC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            if (i == 4) chk("perf_dogru5", {28'd0, dogru_sayac_o}, 32'd5);
        end
        chk("perf_dogru_sat", {28'd0, dogru_sayac_o}, 32'd15);
        repeat (3) upd(32'h8FC, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("perf_yanlis3", {28'd0, yanlis_sayac_o}, 32'd3);
        chk("perf_dogru_held", {28'd0, dogru_sayac_o}, 32'd15);
        yurut_hatali_tahmin_i = 1'b1;
        @(posedge clk);
        #1;
        yurut_hatali_tahmin_i = 1'b0;
        chk("perf_no_strobe", {28'd0, yanlis_sayac_o}, 32'd3);

        // mid-run reset discards learned state in one cycle
        upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        look("pre_rst", 32'h100, 1'b0, 32'h200);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_dogru", {28'd0, dogru_sayac_o}, 32'd0);
        chk("mid_rst_yanlis", {28'd0, yanlis_sayac_o}, 32'd0);
        rst_i = 1'b1;
        look("post_rst", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        look("post_rst_train", 32'h100, 1'b0, 32'h300);
        chk("post_rst_dogru", {28'd0, dogru_sayac_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
